// File: rtl/can_ram_pkg.sv
// Shared sizing and FSM state type for the RAM message reader, the RAM and the CAN frame builder.
package can_ram_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned MSGLEN     = 5;
  localparam int unsigned IDX_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } state_t;

endpackage

// File: rtl/ram_msg_buf.sv
// Message capture buffer: one write port fed by the fetch counter, one read port indexed by the stream index.
module ram_msg_buf
  import can_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = can_ram_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH      = can_ram_pkg::MSGLEN,
  parameter int unsigned IDX_WIDTH  = can_ram_pkg::IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ram_msg_reader.sv
// Fetches MSGLEN bytes from a 1-cycle-latency RAM into a buffer, then streams them out over a valid/ready port.
module ram_msg_reader
  import can_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = can_ram_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = can_ram_pkg::ADDR_WIDTH,
  parameter int unsigned MSGLEN     = can_ram_pkg::MSGLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_chipSel,
  output logic                  ram_wriEn,
  output logic                  ram_outEn,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [2:0]            byte_idx,
  output logic                  byte_last
);

  localparam int unsigned CW = IDX_WIDTH + 1;
  localparam logic [CW-1:0]        K_LAST_ISSUE = CW'(MSGLEN - 1);
  localparam logic [CW-1:0]        K_FINAL      = CW'(MSGLEN);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST     = IDX_WIDTH'(MSGLEN - 1);

  state_t state, state_next;

  logic [CW-1:0]         fcnt;
  logic [IDX_WIDTH-1:0]  idx;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  cs_q;
  logic                  oe_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] rd_data;

  logic accept;
  logic capture;
  logic fetch_end;
  logic xfer;
  logic xfer_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    fetch_end  = 1'b0;
    xfer       = 1'b0;
    xfer_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // Data for the address issued in cycle k arrives in cycle k+1.
        capture = (fcnt != '0);
        if (fcnt == K_FINAL) begin
          fetch_end  = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (byte_ready) begin
          xfer = 1'b1;
          if (idx == IDX_LAST) begin
            xfer_last  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt   <= '0;
      idx    <= '0;
      addr_q <= '0;
      cs_q   <= 1'b0;
      oe_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer_last;
      if (accept) begin
        addr_q <= base_addr;
        cs_q   <= 1'b1;
        oe_q   <= 1'b1;
        fcnt   <= '0;
        idx    <= '0;
      end
      if (state == FETCH) begin
        fcnt <= fcnt + CW'(1);
        if (fcnt < K_LAST_ISSUE) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
        // Last issue done; keep output enable up one more cycle for the final capture.
        if (fcnt == K_LAST_ISSUE) begin
          cs_q <= 1'b0;
        end
        if (fetch_end) begin
          oe_q <= 1'b0;
        end
      end
      if (xfer) begin
        idx <= xfer_last ? '0 : idx + IDX_WIDTH'(1);
      end
    end
  end

  assign wr_idx = IDX_WIDTH'(fcnt - CW'(1));

  ram_msg_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MSGLEN),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_idx  (wr_idx),
    .wr_data (ram_data),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign ram_addr    = addr_q;
  assign ram_chipSel = cs_q;
  assign ram_outEn   = oe_q;
  assign ram_wriEn   = 1'b0;
  assign byte_valid  = (state == STREAM);
  assign byte_out    = rd_data;
  assign byte_idx    = idx;
  assign byte_last   = byte_valid && (idx == IDX_LAST);

endmodule
